// File: rtl/fft_pkg.sv
// Shared FFT helpers: index-width functions, radix-4 digit reversal and
// the read-side FSM state encoding used by the reorder buffer.
package fft_pkg;

  localparam int MAX_IDX_W = 16;

  typedef enum logic {IDLE, READ} rd_state_e;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  function automatic int log4n(input int n);
    return $clog2(n) / 2;
  endfunction

  // Reverse the order of the 2-bit base-4 digits in the low idx_w bits.
  function automatic logic [MAX_IDX_W-1:0] digitrev(input logic [MAX_IDX_W-1:0] idx,
                                                    input int idx_w);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int d = 0; d < idx_w / 2; d++)
      r[2*d +: 2] = idx[idx_w-2-2*d +: 2];
    return r;
  endfunction

endpackage

// File: rtl/digit_reverse_reorder_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read
// port; the bank select is the MSB of the flat address.
module pingpong_sample_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 wr_en_i,
  input  logic                 wr_bank_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [2*WIDTH-1:0]   wr_data_i,
  input  logic                 rd_bank_i,
  input  logic [AW-1:0]        rd_addr_i,
  output logic [2*WIDTH-1:0]   rd_data_o
);

  logic [2*WIDTH-1:0] mem_q [2*DEPTH];

  always_ff @(posedge clock)
    if (wr_en_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;

  assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/digit_reverse_reorder.sv
// Radix-4 digit-reversed to natural-order reorder buffer (ping-pong banks).
// Optional output_last flag enabled with macro DIGIT_REORDER_LAST_EN.
module digit_reverse_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_SAMPLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  output logic             output_en,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag,
`ifdef DIGIT_REORDER_LAST_EN
  output logic             output_last,
`endif
  output logic             overflow
);

  localparam int AW = log2n(NUM_SAMPLES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SAMPLES - 1);

  logic [AW-1:0]      wr_cnt_q, rd_cnt_q, rd_addr;
  logic               wr_bank_q, rd_bank_q;
  logic [1:0]         full_q;
  rd_state_e          state_q;
  logic               rd_last, wr_ok, wr_last;
  logic [2*WIDTH-1:0] rd_data;

  assign rd_last = (state_q == READ) && (rd_cnt_q == LAST_IDX);
  // A bank being drained on this very edge is free for the writer: the read
  // sees the old contents, so continuous input never hits a full bank.
  assign wr_ok   = input_en && (!full_q[wr_bank_q] || (rd_last && rd_bank_q == wr_bank_q));
  assign wr_last = wr_ok && (wr_cnt_q == LAST_IDX);
  assign rd_addr = AW'(digitrev(MAX_IDX_W'(rd_cnt_q), AW));

  pingpong_sample_ram #(.WIDTH(WIDTH), .DEPTH(NUM_SAMPLES)) u_ram (
    .clock     (clock),
    .wr_en_i   (wr_ok),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i ({input_real, input_imag}),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (rd_last) full_q[rd_bank_q] <= 1'b0;
      if (input_en && !wr_ok) overflow <= 1'b1;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      output_en   <= 1'b0;
      output_real <= '0;
      output_imag <= '0;
`ifdef DIGIT_REORDER_LAST_EN
      output_last <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          output_en <= 1'b0;
`ifdef DIGIT_REORDER_LAST_EN
          output_last <= 1'b0;
`endif
          if (full_q[rd_bank_q]) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
          end
        end
        READ: begin
          output_en   <= 1'b1;
          output_real <= rd_data[2*WIDTH-1:WIDTH];
          output_imag <= rd_data[WIDTH-1:0];
`ifdef DIGIT_REORDER_LAST_EN
          output_last <= rd_last;
`endif
          rd_cnt_q <= rd_cnt_q + 1'b1;
          if (rd_last) begin
            rd_bank_q <= ~rd_bank_q;
            if (!full_q[~rd_bank_q]) state_q <= IDLE;
          end
        end
      endcase
    end

endmodule
